// File: rtl/register_sequencer.sv
// register_sequencer: issues one register control strobe per cycle for each accepted command
module register_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_fill,
  input  logic                  abort,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_ir,
  output logic                  reg_sl,
  output logic                  reg_il,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] data;
  logic                  fill;
  logic                  ab;
  logic                  accept;
  logic                  rep;
  logic                  single;
  logic                  zero;
  logic                  exec;

  // classify the incoming command: repeat ops take cmd_cnt steps, CLR/LOAD one, the rest none
  always_comb begin
    accept = cmd_valid && state == IDLE;
    rep    = cmd_op >= OP_INC && cmd_op <= OP_SHL;
    single = cmd_op == OP_CLR || cmd_op == OP_LOAD;
    zero   = !single && !(rep && cmd_cnt != '0);
  end

  // IDLE -> EXEC -> DONE -> IDLE; zero-step commands skip EXEC, abort cuts EXEC short
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      op        <= '0;
      data      <= '0;
      fill      <= 1'b0;
      ab        <= 1'b0;
    end else if (accept) begin
      op        <= cmd_op;
      data      <= cmd_data;
      fill      <= cmd_fill;
      ab        <= 1'b0;
      remaining <= rep ? cmd_cnt : single ? CNT_WIDTH'(1) : '0;
      state     <= zero ? DONE : EXEC;
    end else if (state == EXEC) begin
      remaining <= remaining - CNT_WIDTH'(1);
      if (abort) begin
        ab    <= 1'b1;
        state <= DONE;
      end else if (remaining == CNT_WIDTH'(1)) begin
        state <= DONE;
      end
    end else if (state != IDLE) begin
      state <= IDLE;
    end
  end

  assign exec      = state == EXEC;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign aborted   = done && ab;
  assign reg_in    = data;
  assign reg_cl    = exec && op == OP_CLR;
  assign reg_ld    = exec && op == OP_LOAD;
  assign reg_inc   = exec && op == OP_INC;
  assign reg_dec   = exec && op == OP_DEC;
  assign reg_sr    = exec && op == OP_SHR;
  assign reg_sl    = exec && op == OP_SHL;
  assign reg_ir    = reg_sr && fill;
  assign reg_il    = reg_sl && fill;
endmodule
